// File: rtl/ahb_lite_arbiter_2m_if.sv
// Point-to-point AHB-Lite link: "master" drives the address/control/write data,
// "slave" returns read data, ready and response.
interface ahb_lite_arbiter_2m_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master to one-slave AHB-Lite arbiter: each master's address phase is captured
// and the master is stalled until its transfer has been replayed on the shared slave.
module ahb_lite_arbiter_2m #(
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_lite_arbiter_2m_if.slave  m0,
  ahb_lite_arbiter_2m_if.slave  m1,
  ahb_lite_arbiter_2m_if.master s
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR, S_RESP} state_t;

  state_t      r_state;
  logic        r_gnt;
  logic        r_last_gnt;
  logic        r_err;
  logic [1:0]  r_pend;
  logic [31:0] r_addr  [2];
  logic [1:0]  r_write;
  logic [2:0]  r_size  [2];
  logic [3:0]  r_prot  [2];
  logic [31:0] r_rdata [2];

  logic [1:0]  w_hready;
  logic [1:0]  w_req;
  logic        w_pick;
  logic        w_err_out;
  logic        w_unused;

  assign w_hready[0] = ~r_pend[0] | ((r_state == S_RESP) & ~r_gnt);
  assign w_hready[1] = ~r_pend[1] | ((r_state == S_RESP) &  r_gnt);
  assign w_req[0]    = w_hready[0] & m0.HSEL & m0.HTRANS[1];
  assign w_req[1]    = w_hready[1] & m1.HSEL & m1.HTRANS[1];
  assign w_err_out   = (r_state == S_ERR) | ((r_state == S_RESP) & r_err);

  // A lone requester always wins; a tie goes to the master not served last unless fixed priority.
  always_comb begin
    if (r_pend == 2'b11) w_pick = PRIORITY_MODE ? 1'b0 : ~r_last_gnt;
    else                 w_pick = r_pend[1];
  end

  assign m0.HREADY = w_hready[0];
  assign m1.HREADY = w_hready[1];
  assign m0.HRESP  = w_err_out & ~r_gnt;
  assign m1.HRESP  = w_err_out &  r_gnt;
  assign m0.HRDATA = r_rdata[0];
  assign m1.HRDATA = r_rdata[1];

  assign s.HSEL   = (r_state == S_ADDR);
  assign s.HTRANS = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign s.HADDR  = r_addr[r_gnt];
  assign s.HWRITE = r_write[r_gnt];
  assign s.HSIZE  = r_size[r_gnt];
  assign s.HPROT  = r_prot[r_gnt];
  assign s.HBURST = 3'b000;
  assign s.HWDATA = r_gnt ? m1.HWDATA : m0.HWDATA;

  // Burst type and the SEQ/NONSEQ distinction are irrelevant: every transfer is replayed as SINGLE.
  assign w_unused = ^{m0.HBURST, m1.HBURST, m0.HTRANS[0], m1.HTRANS[0]};

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_err      <= 1'b0;
      r_pend     <= 2'b00;
      r_write    <= 2'b00;
      r_addr[0]  <= '0;
      r_addr[1]  <= '0;
      r_size[0]  <= '0;
      r_size[1]  <= '0;
      r_prot[0]  <= '0;
      r_prot[1]  <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      // A fresh capture in the master's own response cycle must beat the clear.
      if (w_req[0]) begin
        r_pend[0]  <= 1'b1;
        r_addr[0]  <= m0.HADDR;
        r_write[0] <= m0.HWRITE;
        r_size[0]  <= m0.HSIZE;
        r_prot[0]  <= m0.HPROT;
      end else if ((r_state == S_RESP) && !r_gnt) begin
        r_pend[0] <= 1'b0;
      end

      if (w_req[1]) begin
        r_pend[1]  <= 1'b1;
        r_addr[1]  <= m1.HADDR;
        r_write[1] <= m1.HWRITE;
        r_size[1]  <= m1.HSIZE;
        r_prot[1]  <= m1.HPROT;
      end else if ((r_state == S_RESP) && r_gnt) begin
        r_pend[1] <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (|r_pend) begin
            r_gnt   <= w_pick;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (s.HREADY) r_state <= S_DATA;
        end
        S_DATA: begin
          if (s.HREADY) begin
            r_rdata[r_gnt] <= s.HRDATA;
            r_err          <= s.HRESP;
            r_state        <= s.HRESP ? S_ERR : S_RESP;
          end
        end
        S_ERR: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_last_gnt <= r_gnt;
          r_err      <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench: a round-robin arbiter in front of a wait-state/error capable memory,
// and a fixed-priority arbiter in front of a zero-wait always-OK slave.
module tb_ahb_lite_arbiter_2m;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_arbiter_2m_if m0A ();
  ahb_lite_arbiter_2m_if m1A ();
  ahb_lite_arbiter_2m_if sA ();
  ahb_lite_arbiter_2m_if m0B ();
  ahb_lite_arbiter_2m_if m1B ();
  ahb_lite_arbiter_2m_if sB ();

  ahb_lite_arbiter_2m #(.PRIORITY_MODE(1'b0)) dutA (
    .HCLK(HCLK), .HRESETn(HRESETn), .m0(m0A), .m1(m1A), .s(sA)
  );

  ahb_lite_arbiter_2m #(.PRIORITY_MODE(1'b1)) dutB (
    .HCLK(HCLK), .HRESETn(HRESETn), .m0(m0B), .m1(m1B), .s(sB)
  );

  int testsRun = 0;
  int failCount = 0;

  // Memory-like slave behind the round-robin arbiter, with programmable waits and an error address.
  logic [31:0] memA [64] = '{default: 32'h0};
  logic [31:0] logA [32] = '{default: 32'h0};
  int          logCnt = 0;
  logic        dpActive = 1'b0;
  logic        dpWrite = 1'b0;
  logic        dpErr = 1'b0;
  logic        errStage = 1'b0;
  logic [5:0]  dpIdx = 6'd0;
  int          waitCnt = 0;
  int          waitCfg = 0;
  logic [31:0] errAddr = 32'hFFFF_FFFF;

  assign sA.HREADY = !dpActive || (waitCnt == 0 && (!dpErr || errStage));
  assign sA.HRESP  = dpActive && (waitCnt == 0) && dpErr;
  assign sA.HRDATA = dpActive ? memA[dpIdx] : 32'h0;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dpActive <= 1'b0;
      errStage <= 1'b0;
      waitCnt  <= 0;
      memA[4]  <= 32'hCAFE_0001;
    end else if (dpActive) begin
      if (waitCnt > 0) begin
        waitCnt <= waitCnt - 1;
      end else if (dpErr && !errStage) begin
        errStage <= 1'b1;
      end else begin
        if (dpWrite) memA[dpIdx] <= sA.HWDATA;
        dpActive <= 1'b0;
        errStage <= 1'b0;
      end
    end else if (sA.HSEL && sA.HTRANS[1]) begin
      dpActive       <= 1'b1;
      dpWrite        <= sA.HWRITE;
      dpIdx          <= sA.HADDR[7:2];
      dpErr          <= (sA.HADDR == errAddr);
      waitCnt        <= waitCfg;
      errStage       <= 1'b0;
      logA[logCnt % 32] <= sA.HADDR;
      logCnt         <= logCnt + 1;
    end
  end

  // Slave behind the fixed-priority arbiter never stalls and never errors.
  assign sB.HREADY = 1'b1;
  assign sB.HRESP  = 1'b0;
  assign sB.HRDATA = 32'h0;

  // Watchdog so that a wedged design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // m: 0/1 = masters of the round-robin arbiter, 2/3 = masters of the fixed-priority arbiter.
  task automatic applyStimulus(input int m, input logic sel, input logic [31:0] addr,
                               input logic wr, input logic [31:0] wdata);
    logic [1:0] trans;
    trans = sel ? 2'b10 : 2'b00;
    case (m)
      0: begin
        m0A.HSEL = sel; m0A.HTRANS = trans; m0A.HADDR = addr; m0A.HWRITE = wr;
        if (wr) m0A.HWDATA = wdata;
      end
      1: begin
        m1A.HSEL = sel; m1A.HTRANS = trans; m1A.HADDR = addr; m1A.HWRITE = wr;
        if (wr) m1A.HWDATA = wdata;
      end
      2: begin
        m0B.HSEL = sel; m0B.HTRANS = trans; m0B.HADDR = addr; m0B.HWRITE = wr;
        if (wr) m0B.HWDATA = wdata;
      end
      default: begin
        m1B.HSEL = sel; m1B.HTRANS = trans; m1B.HADDR = addr; m1B.HWRITE = wr;
        if (wr) m1B.HWDATA = wdata;
      end
    endcase
  endtask

  function automatic logic readyOf(input int m);
    return (m == 0) ? m0A.HREADY : m1A.HREADY;
  endfunction

  // Waits (bounded) until the given round-robin master sees HREADY high again.
  task automatic waitReady(input int m, input string tag);
    int n;
    for (n = 0; n < 40; n++) begin
      if (readyOf(m) === 1'b1) break;
      tick;
    end
    checkOutput(tag, (n < 40), 32'd1);
  endtask

  task automatic resetDut;
    HRESETn = 1'b0;
    tick;
    tick;
    HRESETn = 1'b1;
  endtask

  initial begin
    int base;
    int lowCnt;
    int n;
    int m0Grants;
    int m1Grants;
    int extraM0;
    logic gotM1;

    m0A.HSIZE = 3'b010; m0A.HPROT = 4'b0011; m0A.HBURST = 3'b001; m0A.HWDATA = 32'h0;
    m1A.HSIZE = 3'b010; m1A.HPROT = 4'b0011; m1A.HBURST = 3'b001; m1A.HWDATA = 32'h0;
    m0B.HSIZE = 3'b010; m0B.HPROT = 4'b0011; m0B.HBURST = 3'b000; m0B.HWDATA = 32'h0;
    m1B.HSIZE = 3'b010; m1B.HPROT = 4'b0011; m1B.HBURST = 3'b000; m1B.HWDATA = 32'h0;
    for (int m = 0; m < 4; m++) applyStimulus(m, 1'b0, 32'h0, 1'b0, 32'h0);
    resetDut;

    // Reset values
    checkOutput("rst_m0_hready", m0A.HREADY, 32'd1);
    checkOutput("rst_m1_hready", m1A.HREADY, 32'd1);
    checkOutput("rst_m0_hrdata", m0A.HRDATA, 32'h0);
    checkOutput("rst_m0_hresp",  m0A.HRESP,  32'd0);
    checkOutput("rst_s_hsel",    sA.HSEL,    32'd0);
    checkOutput("rst_s_htrans",  sA.HTRANS,  32'd0);
    checkOutput("rst_s_haddr",   sA.HADDR,   32'h0);
    checkOutput("rst_b_hready",  m1B.HREADY, 32'd1);

    // Test 1: M0 read 0x10 with two slave wait states
    waitCfg = 2;
    applyStimulus(0, 1'b1, 32'h10, 1'b0, 32'h0);
    tick;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t1_stall_first", m0A.HREADY, 32'd0);
    checkOutput("t1_no_early_sel", sA.HSEL, 32'd0);
    tick;
    checkOutput("t1_s_hsel",   sA.HSEL,   32'd1);
    checkOutput("t1_s_htrans", sA.HTRANS, 32'd2);
    checkOutput("t1_s_haddr",  sA.HADDR,  32'h10);
    checkOutput("t1_s_hwrite", sA.HWRITE, 32'd0);
    checkOutput("t1_s_hsize",  sA.HSIZE,  32'd2);
    checkOutput("t1_s_hprot",  sA.HPROT,  32'h3);
    checkOutput("t1_s_hburst", sA.HBURST, 32'd0);
    lowCnt = 2;
    for (n = 0; n < 20; n++) begin
      tick;
      if (m0A.HREADY === 1'b1) break;
      lowCnt++;
    end
    checkOutput("t1_stall_cycles", lowCnt, 32'd5);
    checkOutput("t1_hrdata", m0A.HRDATA, 32'hCAFE_0001);
    checkOutput("t1_hresp",  m0A.HRESP,  32'd0);
    checkOutput("t1_m1_idle_ready", m1A.HREADY, 32'd1);
    tick;

    // Test 2: simultaneous writes after reset, round-robin ordering
    waitCfg = 0;
    resetDut;
    base = logCnt;
    applyStimulus(0, 1'b1, 32'h20, 1'b1, 32'h11);
    applyStimulus(1, 1'b1, 32'h24, 1'b1, 32'h22);
    tick;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (12) tick;
    checkOutput("t2_count_r1", logCnt - base, 32'd2);
    checkOutput("t2_first_m0", logA[base], 32'h20);
    checkOutput("t2_second_m1", logA[base + 1], 32'h24);
    applyStimulus(0, 1'b1, 32'h20, 1'b0, 32'h0);
    tick;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    waitReady(0, "t2_read_timeout");
    checkOutput("t2_read_back", m0A.HRDATA, 32'h11);
    tick;
    applyStimulus(0, 1'b1, 32'h20, 1'b1, 32'h11);
    applyStimulus(1, 1'b1, 32'h24, 1'b1, 32'h22);
    tick;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (12) tick;
    checkOutput("t2_tie_m1_first", logA[base + 3], 32'h24);
    checkOutput("t2_tie_m0_second", logA[base + 4], 32'h20);
    checkOutput("t2_mem_20", memA[8], 32'h11);
    checkOutput("t2_mem_24", memA[9], 32'h22);

    // Test 4: slave error on M1 read 0x40
    errAddr = 32'h40;
    applyStimulus(1, 1'b1, 32'h40, 1'b0, 32'h0);
    tick;
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (n = 0; n < 20; n++) begin
      if (m1A.HRESP === 1'b1) break;
      tick;
    end
    checkOutput("t4_err_seen", (n < 20), 32'd1);
    checkOutput("t4_err1_hready", m1A.HREADY, 32'd0);
    checkOutput("t4_m0_hready", m0A.HREADY, 32'd1);
    checkOutput("t4_m0_hresp", m0A.HRESP, 32'd0);
    tick;
    checkOutput("t4_err2_hresp", m1A.HRESP, 32'd1);
    checkOutput("t4_err2_hready", m1A.HREADY, 32'd1);
    tick;
    checkOutput("t4_err_done", m1A.HRESP, 32'd0);
    checkOutput("t4_m0_hrdata_kept", m0A.HRDATA, 32'h11);
    errAddr = 32'hFFFF_FFFF;

    // Test 5: reset while the slave data phase is in flight
    waitCfg = 3;
    applyStimulus(0, 1'b1, 32'h10, 1'b0, 32'h0);
    tick;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    tick;
    checkOutput("t5_in_data_sel", sA.HSEL, 32'd0);
    checkOutput("t5_in_data_stall", m0A.HREADY, 32'd0);
    HRESETn = 1'b0;
    tick;
    checkOutput("t5_rst_hready", m0A.HREADY, 32'd1);
    checkOutput("t5_rst_hrdata", m0A.HRDATA, 32'h0);
    checkOutput("t5_rst_hresp",  m0A.HRESP,  32'd0);
    checkOutput("t5_rst_s_hsel", sA.HSEL,    32'd0);
    checkOutput("t5_rst_s_htrans", sA.HTRANS, 32'd0);
    checkOutput("t5_rst_s_haddr", sA.HADDR,  32'h0);
    HRESETn = 1'b1;
    waitCfg = 0;
    applyStimulus(0, 1'b1, 32'h24, 1'b0, 32'h0);
    tick;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    waitReady(0, "t5_after_rst_timeout");
    checkOutput("t5_after_rst_data", m0A.HRDATA, 32'h22);
    checkOutput("t5_after_rst_resp", m0A.HRESP, 32'd0);
    tick;

    // Test 6: M0 issues its next transfer during its own response cycle
    base = logCnt;
    applyStimulus(0, 1'b1, 32'h30, 1'b1, 32'h55);
    tick;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    waitReady(0, "t6_first_timeout");
    applyStimulus(0, 1'b1, 32'h24, 1'b0, 32'h0);
    tick;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t6_pend_kept", m0A.HREADY, 32'd0);
    waitReady(0, "t6_second_timeout");
    checkOutput("t6_second_data", m0A.HRDATA, 32'h22);
    checkOutput("t6_log_first", logA[base], 32'h30);
    checkOutput("t6_log_second", logA[base + 1], 32'h24);
    checkOutput("t6_mem_30", memA[12], 32'h55);
    tick;

    // Test 3: fixed priority, both masters requesting continuously
    m0Grants = 0;
    m1Grants = 0;
    applyStimulus(2, 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(3, 1'b1, 32'h200, 1'b0, 32'h0);
    for (int i = 0; i < 24; i++) begin
      tick;
      if (sB.HSEL === 1'b1) begin
        if (sB.HADDR == 32'h200) m1Grants++;
        else m0Grants++;
      end
    end
    checkOutput("t3_m1_starved", m1Grants, 32'd0);
    checkOutput("t3_m0_grants", m0Grants, 32'd6);
    applyStimulus(2, 1'b0, 32'h0, 1'b0, 32'h0);
    gotM1 = 1'b0;
    extraM0 = 0;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (sB.HSEL === 1'b1) begin
        if (sB.HADDR == 32'h200) begin
          gotM1 = 1'b1;
          break;
        end
        extraM0++;
      end
    end
    checkOutput("t3_m1_served", gotM1, 32'd1);
    checkOutput("t3_no_extra_m0", extraM0, 32'd0);
    applyStimulus(3, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) tick;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
